// File: rtl/fifo_pkg.sv
// Shared types and helpers for the level-reporting FIFO.
package fifo_pkg;

  typedef enum logic {FIFO_MODE_REG, FIFO_MODE_FWFT} fifo_mode_t;

  // Wrapping pointer increment for arbitrary (non power-of-two) depths.
  function automatic int unsigned ptr_incr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

  // Width needed to hold an entry count in the range 0..depth.
  function automatic int lvl_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_lvl.sv
// Single-clock FIFO with fill level, almost-full/empty thresholds,
// sticky error flags, synchronous flush and selectable read mode.
module fifo_lvl
  import fifo_pkg::*;
#(
  parameter int         DEPTH     = 8,
  parameter int         WIDTH     = 8,
  parameter int         AFULL_TH  = DEPTH - 1,
  parameter int         AEMPTY_TH = 1,
  parameter fifo_mode_t MODE      = FIFO_MODE_FWFT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      clr_err,
  input  logic                      push,
  input  logic [WIDTH-1:0]          wdata,
  input  logic                      pop,
  output logic [WIDTH-1:0]          rdata,
  output logic                      rdata_valid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);

  if (DEPTH < 2 || WIDTH < 1 || AFULL_TH < 1 || AFULL_TH > DEPTH ||
      AEMPTY_TH < 0 || AEMPTY_TH > DEPTH - 1) begin : g_param_err
    $error("fifo_lvl: parameter out of range (DEPTH=%0d WIDTH=%0d AFULL_TH=%0d AEMPTY_TH=%0d)",
           DEPTH, WIDTH, AFULL_TH, AEMPTY_TH);
  end

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [WIDTH-1:0] mem_rdata;
  logic             pop_ok;
  logic             push_ok;
  logic             pop_acc;
  logic             push_acc;

  // Status decodes come from the registered level only.
  assign empty        = (level == '0);
  assign full         = (level == LW'(DEPTH));
  assign almost_full  = (level >= LW'(AFULL_TH));
  assign almost_empty = (level <= LW'(AEMPTY_TH));

  // A push into a full FIFO is legal when the head is popped in the same cycle.
  assign pop_ok   = pop && !empty;
  assign push_ok  = push && (!full || pop_ok);
  assign pop_acc  = pop_ok && !flush;
  assign push_acc = push_ok && !flush;

  // Pointers, level and sticky error flags; flush wins over everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_acc) wptr <= PW'(ptr_incr(32'(wptr), 32'(DEPTH)));
      if (pop_acc)  rptr <= PW'(ptr_incr(32'(rptr), 32'(DEPTH)));
      level <= level + LW'(push_acc) - LW'(pop_acc);
      if (push && !push_ok)  overflow  <= 1'b1;
      else if (clr_err)      overflow  <= 1'b0;
      if (pop && !pop_ok)    underflow <= 1'b1;
      else if (clr_err)      underflow <= 1'b0;
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wptr),
    .wdata (wdata),
    .raddr (rptr),
    .rdata (mem_rdata)
  );

  if (MODE == FIFO_MODE_FWFT) begin : g_fwft
    assign rdata       = mem_rdata;
    assign rdata_valid = !empty;
  end else begin : g_reg
    logic [WIDTH-1:0] rdata_p1;
    logic             vld_p1;

    // Registered read: head word captured on an accepted pop, valid for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rdata_p1 <= '0;
        vld_p1   <= 1'b0;
      end else if (flush) begin
        vld_p1   <= 1'b0;
      end else begin
        vld_p1 <= pop_acc;
        if (pop_acc) rdata_p1 <= mem_rdata;
      end
    end

    assign rdata       = rdata_p1;
    assign rdata_valid = vld_p1;
  end

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
Parametrised synchronous single-clock FIFO: next generation of the team's small FIFO, intended for UART/SPI RX/TX buffering and peripheral data paths.
- Adds arbitrary (non power-of-two) depth, fill-level output and programmable almost-full/almost-empty thresholds.
- Adds sticky overflow/underflow error flags, synchronous flush and a selectable read mode (first-word-fall-through or registered).

Parameters:
- DEPTH, 8, number of entries; ≥2, any integer.
- WIDTH, 8, data width in bits; ≥1.
- AFULL_TH, DEPTH-1, almost_full asserted when level ≥ AFULL_TH; 1..DEPTH.
- AEMPTY_TH, 1, almost_empty asserted when level ≤ AEMPTY_TH; 0..DEPTH-1.
- MODE, FIFO_MODE_FWFT, read mode of type fifo_pkg::fifo_mode_t: FIFO_MODE_FWFT or FIFO_MODE_REG.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- clr_err  in  1  clears overflow/underflow.
- push  in  1  write request.
- wdata  in  WIDTH  write data.
- pop  in  1  read request.
- rdata  out  WIDTH  read data.
- rdata_valid  out  1  rdata qualifier.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- almost_full  out  1  level ≥ AFULL_TH.
- almost_empty  out  1  level ≤ AEMPTY_TH.
- level  out  $clog2(DEPTH+1)  current entry count.
- overflow  out  1  sticky: push rejected.
- underflow  out  1  sticky: pop rejected.

Behaviour:
- Reset (async, rst_n low):
  - wptr = rptr = 0, level = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = underflow = 0, rdata_valid = 0; rdata = 0 in REG mode.
  - Memory contents are not reset.
- Status flags are combinational decodes of the registered level only; no combinational path from push/pop to any status output.
- pop_acc = pop && !empty.
- push_acc = push && (!full || pop_acc).
  - Push while full with a simultaneous accepted pop is accepted: the freed slot is written.
  - Old head data is still read correctly in both modes because the read happens before the edge.
- Push + pop while empty: push accepted, pop rejected. No bypass of wdata to rdata.
- level_next = level + push_acc - pop_acc; level never exceeds DEPTH and never goes below 0.
- Pointers advance by 1 on accept; DEPTH-1 wraps to 0 (explicit compare, not power-of-two masking).
- Write: mem[wptr] <= wdata on push_acc.
- FWFT mode:
  - rdata = mem[rptr] (combinational from state).
  - rdata_valid = !empty.
  - pop consumes the currently presented word; the next word appears the cycle after.
- REG mode:
  - On pop_acc, rdata <= mem[rptr]; rdata_valid is 1 for exactly the following cycle, else 0.
  - rdata holds its last value when no pop is accepted.
  - Latency: pop accepted at edge N gives data at edge N+1.
- Error flags:
  - overflow set on push && !push_acc; underflow set on pop && !pop_acc.
  - Both clear on clr_err; set has priority over clr_err in the same cycle.
  - Both clear on flush.
- flush:
  - Next edge: wptr = rptr = level = 0, rdata_valid = 0, errors cleared.
  - push/pop in the flush cycle are ignored and flag no errors. rdata in REG mode keeps its value.
- Reset mid-operation: all state returns to reset values immediately (async). Any pending REG-mode rdata_valid is dropped.
- Elaboration: an out-of-range parameter triggers $error via a generate-time check.

Decomposition:
- Package fifo_pkg holds:
  - typedef enum logic {FIFO_MODE_REG, FIFO_MODE_FWFT} fifo_mode_t.
  - Function ptr_incr(ptr, depth) for wrapping increment.
  - Function lvl_w(depth) returning $clog2(depth+1).
- Sub-module fifo_mem (parameters DEPTH, WIDTH) holds the storage array:
  - One synchronous write port (we, waddr, wdata).
  - One asynchronous read port (raddr, rdata).
- fifo_lvl holds pointers, level, flags, error logic and the read-mode generate branch.

Test Plan:
- DEPTH=5, FWFT: push 0x11..0x15 → level 1..5, almost_full at level 4, full at 5. Pop 5 times → data 0x11..0x15 in order, pointers wrap past 4, empty=1 at end.
- DEPTH=4, full: push 0xAA with no pop → overflow=1, level stays 4, contents unchanged. Push 0xBB with pop in the same cycle → head popped, level stays 4, 0xBB becomes last entry.
- Empty FIFO: pop → underflow=1, level 0. clr_err and pop together → underflow stays 1. clr_err alone → 0.
- REG mode, 2 entries 0x01, 0x02: pop at edge N → rdata=0x01 and rdata_valid=1 for one cycle after N. Back-to-back pops → 0x01, 0x02 with rdata_valid high 2 cycles. Then rdata_valid=0 and rdata holds 0x02.
- Level 3 with overflow=1: assert flush together with push → next cycle level=0, empty=1, overflow=0, pushed data not stored.
- rst_n pulled low asynchronously mid-burst at level 2 → all outputs at reset values before the next clock edge; the first push after release lands at index 0.
